// File: rtl/vga_timing_pkg.sv
// Shared mode constants and sizing helpers for the VGA raster timing generator.
package vga_timing_pkg;

   // Region of one raster axis, in the order the counter walks through them.
   typedef enum logic [1:0] {
      REG_SYNC,
      REG_BP,
      REG_ACTIVE,
      REG_FP
   } region_e;

   // 640x480@60, 25.175 MHz nominal pixel clock (the default mode).
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam bit VGA640_HS_POL   = 1'b0;
   localparam bit VGA640_VS_POL   = 1'b0;

   // 800x600@60, 40 MHz nominal pixel clock, positive sync pulses.
   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BP     = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BP     = 23;
   localparam bit SVGA800_HS_POL   = 1'b1;
   localparam bit SVGA800_VS_POL   = 1'b1;

   // Length of a full line or frame from its four segments.
   function automatic int seg_total(input int sync, input int bp, input int active, input int fp);
      return sync + bp + active + fp;
   endfunction

   // Smallest counter width that can hold every position of both axes.
   function automatic int min_cw(input int h_total, input int v_total);
      int m;
      int w;
      m = (h_total > v_total) ? h_total : v_total;
      w = 1;
      while ((1 << w) < m) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with registered sync, active
// and active-relative coordinate decoded from the position it is moving to.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter bit POL    = 1'b0,
   parameter int CW     = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          sync,
   output logic          active,
   output logic [CW-1:0] coord,
   output logic          wrap
);

   localparam int            TOTAL = seg_total(SYNC, BP, ACTIVE, FP);
   localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
   localparam logic [CW-1:0] BP0   = CW'(SYNC);
   localparam logic [CW-1:0] A0    = CW'(SYNC + BP);
   localparam logic [CW-1:0] FP0   = CW'(SYNC + BP + ACTIVE);

   logic [CW-1:0] count_next;
   region_e       region_next;

   // Advance the position; wrap is combinational so the next axis can step on the same edge.
   always_comb begin
      wrap       = inc && (count == LAST);
      count_next = count;
      if (inc) begin
         count_next = wrap ? '0 : count + 1'b1;
      end
   end

   // Classify the upcoming position so the registered decode lines up with the count.
   always_comb begin
      if (count_next < BP0) begin
         region_next = REG_SYNC;
      end else if (count_next < A0) begin
         region_next = REG_BP;
      end else if (count_next < FP0) begin
         region_next = REG_ACTIVE;
      end else begin
         region_next = REG_FP;
      end
   end

   // Position and decoded levels all hold while inc is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         sync   <= POL;
         active <= 1'b0;
         coord  <= '0;
      end else if (inc) begin
         count  <= count_next;
         sync   <= (region_next == REG_SYNC) ? POL : ~POL;
         active <= (region_next == REG_ACTIVE);
         coord  <= (region_next == REG_ACTIVE) ? count_next - A0 : '0;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: two axis counters, the active-area
// combine and the line/frame strobes.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter bit HS_POL   = VGA640_HS_POL,
   parameter bit VS_POL   = VGA640_VS_POL,
   parameter int CW       = 11
) (
   input  logic          clk25,
   input  logic          rst_n,
   input  logic          pix_en,
   output logic          hs,
   output logic          vs,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = seg_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
   localparam int V_TOTAL = seg_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

   // A counter too narrow for the raster, or an empty porch/sync, is a build error.
   if (CW < min_cw(H_TOTAL, V_TOTAL) || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_cfg_error
      $fatal(1, "vga_timing_gen: illegal timing parameters");
   end

   logic [CW-1:0] hcnt;
   logic [CW-1:0] vcnt;
   logic [CW-1:0] h_coord;
   logic [CW-1:0] v_coord;
   logic          h_active;
   logic          v_active;
   logic          h_wrap;
   logic          v_wrap;
   logic          v_inc;

   // The raw counts are kept on the axis ports for probing but not driven out.
   logic unused_counts;
   assign unused_counts = ^{hcnt, vcnt};

   assign v_inc = pix_en & h_wrap;

   vga_axis_counter #(
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .POL    (HS_POL),
      .CW     (CW)
   ) u_h_axis (
      .clk    (clk25),
      .rst_n  (rst_n),
      .inc    (pix_en),
      .count  (hcnt),
      .sync   (hs),
      .active (h_active),
      .coord  (h_coord),
      .wrap   (h_wrap)
   );

   vga_axis_counter #(
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .POL    (VS_POL),
      .CW     (CW)
   ) u_v_axis (
      .clk    (clk25),
      .rst_n  (rst_n),
      .inc    (v_inc),
      .count  (vcnt),
      .sync   (vs),
      .active (v_active),
      .coord  (v_coord),
      .wrap   (v_wrap)
   );

   // Each axis coordinate is already zero outside its own active span; gate by the other axis.
   assign de = h_active & v_active;
   assign x  = v_active ? h_coord : '0;
   assign y  = h_active ? v_coord : '0;

   // Strobes fire on the edge that lands the position on hcnt=0 / (0,0) by wrapping.
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= h_wrap;
         frame_start <= v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a default 640x480 instance and a tiny
// 7x6 instance share the stimulus and are both tracked by a position model.
module tb_vga_timing_gen;

   logic        clk25 = 1'b0;
   logic        rst_n = 1'b1;
   logic        pix_en = 1'b0;

   logic        d_hs, d_vs, d_de, d_line_start, d_frame_start;
   logic [10:0] d_x, d_y;
   logic        s_hs, s_vs, s_de, s_line_start, s_frame_start;
   logic [2:0]  s_x, s_y;

   int tests_run = 0;
   int tests_failed = 0;

   // Model position and expected strobes for each instance.
   int  dh = 0, dv = 0, sh = 0, sv = 0;
   bit  d_ls = 0, d_fs = 0, s_ls = 0, s_fs = 0;

   // Run statistics gathered from the default instance.
   int  cyc = 0;
   int  de_clocks = 0, line_pulses = 0, small_frames = 0, max_x = 0, first_de = -1;

   typedef struct {
      bit pe;
      bit hs, vs, de;
      int x, y;
      bit ls, fs;
   } vec_t;

   vec_t tbl[21];

   vga_timing_gen u_dut_default (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .hs          (d_hs),
      .vs          (d_vs),
      .de          (d_de),
      .x           (d_x),
      .y           (d_y),
      .line_start  (d_line_start),
      .frame_start (d_frame_start)
   );

   vga_timing_gen #(
      .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
      .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .HS_POL   (1'b1), .VS_POL (1'b1), .CW (3)
   ) u_dut_small (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .hs          (s_hs),
      .vs          (s_vs),
      .de          (s_de),
      .x           (s_x),
      .y           (s_y),
      .line_start  (s_line_start),
      .frame_start (s_frame_start)
   );

   always #20 clk25 = ~clk25;

   task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected output bundle for a raster position, straight from the region rules.
   function automatic logic [63:0] expect_vec(input int h, input int v,
                                              input int hsw, input int hbp, input int hact,
                                              input int vsw, input int vbp, input int vact,
                                              input bit hpol, input bit vpol,
                                              input bit ls, input bit fs, input int cw);
      bit ehs, evs, ede;
      int ex, ey;
      logic [63:0] r;
      ehs = (h < hsw) ? hpol : !hpol;
      evs = (v < vsw) ? vpol : !vpol;
      ede = (h >= hsw + hbp) && (h < hsw + hbp + hact) &&
            (v >= vsw + vbp) && (v < vsw + vbp + vact);
      ex  = ede ? h - (hsw + hbp) : 0;
      ey  = ede ? v - (vsw + vbp) : 0;
      r = 64'(ehs);
      r = (r << 1) | 64'(evs);
      r = (r << 1) | 64'(ede);
      r = (r << cw) | 64'(ex);
      r = (r << cw) | 64'(ey);
      r = (r << 1) | 64'(ls);
      r = (r << 1) | 64'(fs);
      return r;
   endfunction

   task automatic step(inout int h, inout int v, input int ht, input int vt,
                       output bit ls, output bit fs);
      h = (h + 1) % ht;
      if (h == 0) v = (v + 1) % vt;
      ls = (h == 0);
      fs = (h == 0) && (v == 0);
   endtask

   task automatic checkOutput();
      compare("default_outputs",
              64'({d_hs, d_vs, d_de, d_x, d_y, d_line_start, d_frame_start}),
              expect_vec(dh, dv, 96, 48, 640, 2, 33, 480, 1'b0, 1'b0, d_ls, d_fs, 11));
      compare("small_outputs",
              64'({s_hs, s_vs, s_de, s_x, s_y, s_line_start, s_frame_start}),
              expect_vec(sh, sv, 1, 1, 4, 1, 1, 3, 1'b1, 1'b1, s_ls, s_fs, 3));
   endtask

   // One clock with the given pixel enable, then model update and check.
   task automatic applyStimulus(input bit pe);
      pix_en = pe;
      @(posedge clk25);
      if (pe) begin
         step(dh, dv, 800, 525, d_ls, d_fs);
         step(sh, sv, 7, 6, s_ls, s_fs);
      end else begin
         d_ls = 0; d_fs = 0; s_ls = 0; s_fs = 0;
      end
      #1;
      checkOutput();
      cyc++;
      if (d_de === 1'b1) begin
         de_clocks++;
         if (first_de < 0) first_de = cyc;
         if (int'(d_x) > max_x) max_x = int'(d_x);
      end
      if (d_line_start === 1'b1) line_pulses++;
      if (s_frame_start === 1'b1) small_frames++;
   endtask

   // Asynchronous reset: outputs must clear with no clock edge, then release away from an edge.
   task automatic doReset();
      #3;
      rst_n = 1'b0;
      #1;
      dh = 0; dv = 0; sh = 0; sv = 0;
      d_ls = 0; d_fs = 0; s_ls = 0; s_fs = 0;
      checkOutput();
      repeat (2) @(posedge clk25);
      #5;
      checkOutput();
      rst_n = 1'b1;
      cyc = 0; de_clocks = 0; line_pulses = 0; small_frames = 0; max_x = 0; first_de = -1;
   endtask

   initial begin
      // Small-mode walk from reset: H regions 0|1|2..5|6, V regions 0|1|2..4|5, sync high.
      tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 1, 0, 0, 0, 0, 0};
      tbl[3]  = '{1, 0, 1, 0, 0, 0, 0, 0};
      tbl[4]  = '{1, 0, 1, 0, 0, 0, 0, 0};
      tbl[5]  = '{1, 0, 1, 0, 0, 0, 0, 0};
      tbl[6]  = '{1, 0, 1, 0, 0, 0, 0, 0};
      tbl[7]  = '{1, 1, 0, 0, 0, 0, 1, 0};
      tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[11] = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[13] = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[15] = '{1, 1, 0, 0, 0, 0, 1, 0};
      tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 0};
      tbl[17] = '{1, 0, 0, 1, 0, 0, 0, 0};
      tbl[18] = '{1, 0, 0, 1, 1, 0, 0, 0};
      tbl[19] = '{0, 0, 0, 1, 1, 0, 0, 0};
      tbl[20] = '{1, 0, 0, 1, 2, 0, 0, 0};

      #2;
      doReset();

      for (int i = 0; i < 21; i++) begin
         applyStimulus(tbl[i].pe);
         compare($sformatf("table[%0d]", i),
                 64'({s_hs, s_vs, s_de, s_x, s_y, s_line_start, s_frame_start}),
                 64'({tbl[i].hs, tbl[i].vs, tbl[i].de, 3'(tbl[i].x), 3'(tbl[i].y),
                      tbl[i].ls, tbl[i].fs}));
      end

      // Continuous run from a clean reset through the first active line of the default mode.
      doReset();
      for (int i = 0; i < 28800; i++) applyStimulus(1'b1);
      compare("first_de_clock", 64'(first_de), 64'(35 * 800 + 144));
      compare("de_clocks_line35", 64'(de_clocks), 64'(640));
      compare("max_x", 64'(max_x), 64'(639));
      compare("line_pulses", 64'(line_pulses), 64'(28800 / 800));
      compare("small_frame_pulses", 64'(small_frames), 64'(28800 / 42));

      // Strict half-rate toggling, then random enables.
      for (int i = 0; i < 200; i++) applyStimulus(i[0] == 1'b0);
      for (int i = 0; i < 3000; i++) begin
         bit pe;
         pe = 1'($urandom_range(0, 1));
         applyStimulus(pe);
      end

      // Abort mid-frame at hcnt=300 and restart cleanly from (0,0).
      for (int i = 0; i < 1000 && dh != 300; i++) applyStimulus(1'b1);
      doReset();
      for (int i = 0; i < 2000; i++) applyStimulus(1'b1);
      compare("line_pulses_after_abort", 64'(line_pulses), 64'(2));
      compare("small_frames_after_abort", 64'(small_frames), 64'(2000 / 42));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
